cdb_arbiter: RTL and testbench

//   Other end of the execution-unit CDB interface: collects cdb_valid/cdb_data from all EUs
//   (ALU, branch, MULT, DIV, FPU, LSU, ...), grants one EU per cycle and registers the winner.
//   The registered winner is broadcast on the common data bus to the ROB and to every

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_rr.sv | 35 +++
 rtl/cdb_arbiter.sv | 51 +++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB payload type, EU count and EU identifiers shared by the CDB arbiter.
package cdb_arbiter_pkg;
  localparam int XLEN        = 32;
  localparam int ROB_IDX_LEN = 4;
  localparam int EXCEPT_LEN  = 5;
  localparam int FFLAGS_LEN  = 5;
  localparam int CDB_EU_NUM  = 8;

  typedef enum logic [2:0] {
    EU_ALU,
    EU_BRANCH,
    EU_MULT,
    EU_DIV,
    EU_FPU,
    EU_LOAD,
    EU_STORE,
    EU_CSR
  } eu_id_t;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob_idx;
    logic [XLEN-1:0]        value;
    logic                   except_raised;
    logic [EXCEPT_LEN-1:0]  except_code;
    logic [FFLAGS_LEN-1:0]  fflags;
  } cdb_data_t;
endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: one-hot grant among valid requesters, round-robin from an internal pointer or fixed lowest-index priority.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = CDB_EU_NUM,
  parameter bit RR = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] valid_i,
  input  logic         ack_i,
  output logic [N-1:0] grant_o
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr, gidx;
  logic [N-1:0]  mask, hi, sel;

  // Requesters at or above ptr take precedence; otherwise wrap to the lowest valid index.
  always_comb begin
    mask    = RR ? ~((N'(1) << ptr) - N'(1)) : '1;
    hi      = valid_i & mask;
    sel     = |hi ? hi : valid_i;
    grant_o = sel & (~sel + N'(1));
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) gidx = grant_o[i] ? PW'(i) : gidx;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr <= '0;
    else if (ack_i && RR) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one EU result per cycle into a single elastic output slot broadcast on the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_EU       = CDB_EU_NUM,
  parameter bit RR_ARBITER = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [N_EU-1:0] eu_valid_i,
  output logic [N_EU-1:0] eu_ready_o,
  input  cdb_data_t       eu_data_i [N_EU],
  input  logic            rob_ready_i,
  output logic            cdb_valid_o,
  output cdb_data_t       cdb_data_o
);
  logic            free, allow, win_valid;
  logic [N_EU-1:0] req;
  cdb_data_t       win;

  assign free      = !cdb_valid_o || rob_ready_i;
  assign allow     = !rst_i && !flush_i && free;
  assign req       = allow ? eu_valid_i : '0;
  assign win_valid = |eu_ready_o;

  rr_arbiter #(.N(N_EU), .RR(RR_ARBITER)) u_arb (
    .clk_i,
    .rst_i,
    .valid_i (req),
    .ack_i   (win_valid),
    .grant_o (eu_ready_o)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < N_EU; i++) win = eu_ready_o[i] ? eu_data_i[i] : win;
  end

  // Flush empties the slot; otherwise a free slot drains and refills in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cdb_valid_o <= 1'b0;
      cdb_data_o  <= '0;
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
    end else if (free) begin
      cdb_valid_o <= win_valid;
      if (win_valid) cdb_data_o <= win;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a broadcast scoreboard for round-robin and fixed-priority arbiters.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, rob_ready = 1'b0, f_rob_ready = 1'b0;
  logic [7:0] eu_valid = '0, f_valid = '0, eu_ready, f_ready;
  logic       cdb_valid, f_cdb_valid;
  cdb_data_t  eu_data [8];
  cdb_data_t  cdb_data, f_cdb_data;
  cdb_data_t  q[$], fq[$];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_EU(8), .RR_ARBITER(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .eu_valid_i(eu_valid), .eu_ready_o(eu_ready),
    .eu_data_i(eu_data), .rob_ready_i(rob_ready), .cdb_valid_o(cdb_valid), .cdb_data_o(cdb_data)
  );

  cdb_arbiter #(.N_EU(8), .RR_ARBITER(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .eu_valid_i(f_valid), .eu_ready_o(f_ready),
    .eu_data_i(eu_data), .rob_ready_i(f_rob_ready), .cdb_valid_o(f_cdb_valid), .cdb_data_o(f_cdb_data)
  );

  function automatic cdb_data_t mk(int eu);
    cdb_data_t d;
    d.rob_idx       = 4'((eu + 3) % 16);
    d.value         = 32'hC0DE_0000 + 32'(eu * 257);
    d.except_raised = eu[0];
    d.except_code   = 5'(eu + 1);
    d.fflags        = 5'(eu * 3);
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted broadcast must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && cdb_valid && rob_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bcast: unexpected broadcast rob_idx %h", cdb_data.rob_idx);
      end else chk("bcast", 64'(cdb_data), 64'(q.pop_front()));
    end
    if (!rst && f_cdb_valid && f_rob_ready) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fp_bcast: unexpected broadcast rob_idx %h", f_cdb_data.rob_idx);
      end else chk("fp_bcast", 64'(f_cdb_data), 64'(fq.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) eu_data[i] = mk(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_ready", 64'(eu_ready), 64'd0);
    chk("rst_data", 64'(cdb_data), 64'd0);
    chk("rst_fp_valid", 64'(f_cdb_valid), 64'd0);
    step;
    rst = 1'b0;
    // single EU, latency 1
    eu_valid = 8'h04;
    rob_ready = 1'b1;
    q.push_back(mk(2));
    @(negedge clk);
    chk("single_ready", 64'(eu_ready), 64'h04);
    step;
    eu_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_rob_idx", 64'(cdb_data.rob_idx), 64'd5);
    step;
    @(negedge clk);
    chk("drain_valid", 64'(cdb_valid), 64'd0);
    step;
    // fill slot under backpressure, then async reset mid-cycle
    eu_valid = 8'h08;
    rob_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", 64'(eu_ready), 64'h08);
    step;
    eu_valid = 8'h40;
    @(negedge clk);
    chk("pre_rst_full", 64'(cdb_valid), 64'd1);
    chk("pre_rst_stall", 64'(eu_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_ready", 64'(eu_ready), 64'd0);
    chk("async_rst_data", 64'(cdb_data), 64'd0);
    step;
    step;
    eu_valid = '0;
    rst = 1'b0;
    q.delete();
    // round-robin with all EUs valid: ptr restarts at 0
    eu_valid = 8'hFF;
    rob_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      q.push_back(mk(k % 8));
      @(negedge clk);
      chk("rr_grant", 64'(eu_ready), 64'(1) << (k % 8));
      if (k > 0) chk("rr_no_bubble", 64'(cdb_valid), 64'd1);
      step;
    end
    eu_valid = '0;
    @(negedge clk);
    chk("rr_last_valid", 64'(cdb_valid), 64'd1);
    step;
    @(negedge clk);
    chk("rr_drain", 64'(cdb_valid), 64'd0);
    step;
    // backpressure: slot holds, then same-cycle refill
    eu_valid = 8'h20;
    q.push_back(mk(5));
    @(negedge clk);
    chk("bp_grant", 64'(eu_ready), 64'h20);
    step;
    eu_valid = 8'h40;
    rob_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 64'(eu_ready), 64'd0);
      chk("bp_valid", 64'(cdb_valid), 64'd1);
      chk("bp_data", 64'(cdb_data), 64'(mk(5)));
      step;
    end
    rob_ready = 1'b1;
    q.push_back(mk(6));
    @(negedge clk);
    chk("bp_refill", 64'(eu_ready), 64'h40);
    step;
    eu_valid = '0;
    @(negedge clk);
    chk("bp_refill_data", 64'(cdb_data), 64'(mk(6)));
    step;
    @(negedge clk);
    chk("bp_drain", 64'(cdb_valid), 64'd0);
    step;
    // flush blocks the grant even though the ROB drains the slot
    eu_valid = 8'h01;
    rob_ready = 1'b0;
    q.push_back(mk(0));
    @(negedge clk);
    chk("fl_fill", 64'(eu_ready), 64'h01);
    step;
    eu_valid = 8'h10;
    flush = 1'b1;
    rob_ready = 1'b1;
    @(negedge clk);
    chk("fl_no_grant", 64'(eu_ready), 64'd0);
    step;
    flush = 1'b0;
    q.push_back(mk(4));
    @(negedge clk);
    chk("fl_dropped", 64'(cdb_valid), 64'd0);
    chk("fl_after_grant", 64'(eu_ready), 64'h10);
    step;
    eu_valid = '0;
    @(negedge clk);
    chk("fl_after_valid", 64'(cdb_valid), 64'd1);
    step;
    // fixed priority: EU1 always beats EU3
    f_valid = 8'h0A;
    f_rob_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fq.push_back(mk(1));
      @(negedge clk);
      chk("fp_grant", 64'(f_ready), 64'h02);
      step;
    end
    f_valid = 8'h08;
    fq.push_back(mk(3));
    @(negedge clk);
    chk("fp_grant_eu3", 64'(f_ready), 64'h08);
    step;
    f_valid = '0;
    @(negedge clk);
    chk("fp_last_valid", 64'(f_cdb_valid), 64'd1);
    step;
    @(negedge clk);
    chk("fp_drain", 64'(f_cdb_valid), 64'd0);
    chk("q_empty", 64'(q.size()), 64'd0);
    chk("fq_empty", 64'(fq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
